// File: rtl/ethernet_transmitter.sv
// ethernet_transmitter
//   Host-side Ethernet TX path. The host fills one of two frame slots
//   (ping-pong), latches the frame size, then commits the slot. A drain FSM
//   (IDLE -> FETCH -> STREAM) streams committed slots out on an AXI-Stream
//   master, one data_width_p word per beat. A 2-entry output skid (output
//   register plus skid register) keeps the stream bubble-free with tready
//   held high, and holds the data stable while tready is low.
//
//   Optional feature: define ETHERNET_TX_MIN_FRAME_PAD_EN to pad frames
//   shorter than 60 bytes to 60 bytes (padding bytes driven as 0).
//
// Ports
//   clk_i, reset_i           clock, synchronous active-high reset
//   packet_req_o             a free slot is available for host writes
//   packet_wvalid_i/waddr_i/wdata_i/wmask_i   byte-masked word write to fill slot
//   packet_wsize_valid_i/wsize_i              latch frame length (bytes)
//   packet_send_i            commit the fill slot
//   tx_axis_*                AXI-Stream master (tuser tied to 0)
//   transmit_count_o         frames fully sent, saturating at send_count_p
module ethernet_transmitter #(
   parameter int data_width_p = 32,
   parameter int eth_mtu_p    = 2048,
   parameter int send_count_p = (1 << 16) - 1
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   output logic                                 packet_req_o,
   input  logic                                 packet_wvalid_i,
   input  logic [$clog2(eth_mtu_p)-1:0]         packet_waddr_i,
   input  logic [data_width_p-1:0]              packet_wdata_i,
   input  logic [data_width_p/8-1:0]            packet_wmask_i,
   input  logic                                 packet_wsize_valid_i,
   input  logic [$clog2(eth_mtu_p+1)-1:0]       packet_wsize_i,
   input  logic                                 packet_send_i,
   output logic [data_width_p-1:0]              tx_axis_tdata_o,
   output logic [data_width_p/8-1:0]            tx_axis_tkeep_o,
   output logic                                 tx_axis_tvalid_o,
   input  logic                                 tx_axis_tready_i,
   output logic                                 tx_axis_tlast_o,
   output logic                                 tx_axis_tuser_o,
   output logic [$clog2(send_count_p+1)-1:0]    transmit_count_o
);
   localparam int B      = data_width_p / 8;
   localparam int OFF_W  = $clog2(B);
   localparam int ADDR_W = $clog2(eth_mtu_p);
   localparam int SIZE_W = $clog2(eth_mtu_p + 1);
   localparam int WORDS  = eth_mtu_p / B;
   localparam int WIDX_W = ADDR_W - OFF_W;
   localparam int BEAT_W = $clog2(WORDS + 1);
   localparam int CNT_W  = $clog2(send_count_p + 1);

   typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

   function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] sz);
      if (sz > SIZE_W'(eth_mtu_p)) return SIZE_W'(eth_mtu_p);
      return sz;
   endfunction

   // Length actually put on the wire (keep/last follow this, data follows size).
   function automatic logic [SIZE_W-1:0] frame_len(input logic [SIZE_W-1:0] sz);
`ifdef ETHERNET_TX_MIN_FRAME_PAD_EN
      if (sz != '0 && sz < SIZE_W'(60)) return SIZE_W'(60);
`endif
      return sz;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c == CNT_W'(send_count_p)) return c;
      return c + 1'b1;
   endfunction

   logic [data_width_p-1:0] mem_q [2*WORDS];

   state_t                  state_q, state_d;
   logic [SIZE_W-1:0]       size_q [2];
   logic [SIZE_W-1:0]       size_d [2];
   logic [1:0]              committed_q, committed_d;
   logic                    fill_ptr_q, fill_ptr_d, drain_ptr_q, drain_ptr_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [data_width_p-1:0] tdata_q, tdata_d, skid_data_q, skid_data_d;
   logic [B-1:0]            tkeep_q, tkeep_d, skid_keep_q, skid_keep_d;
   logic                    tlast_q, tlast_d, skid_last_q, skid_last_d;
   logic                    tvalid_q, tvalid_d, skid_vld_q, skid_vld_d;

   logic                    host_ok, wr_en, commit, issue, pop, frame_done;
   logic [SIZE_W-1:0]       fill_size, drain_len;
   logic [BEAT_W-1:0]       beats;
   logic [data_width_p-1:0] rd_word, new_data;
   logic [B-1:0]            new_keep;
   logic                    new_last;
   logic                    unused_waddr;

   assign unused_waddr = ^packet_waddr_i[OFF_W-1:0];
   assign host_ok      = ~&committed_q;
   assign wr_en        = packet_wvalid_i && host_ok;

   // Slot storage: the slot index is the MSB of the word address.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int i = 0; i < B; i++) begin
            if (packet_wmask_i[i])
               mem_q[{fill_ptr_q, packet_waddr_i[ADDR_W-1:OFF_W]}][8*i +: 8] <= packet_wdata_i[8*i +: 8];
         end
      end
   end

   // Beat generation for the drain slot.
   always_comb begin
      drain_len = frame_len(size_q[drain_ptr_q]);
      beats     = BEAT_W'((drain_len + SIZE_W'(B - 1)) >> OFF_W);
      rd_word   = mem_q[{drain_ptr_q, beat_q[WIDX_W-1:0]}];
      new_data  = '0;
      new_keep  = '0;
      for (int j = 0; j < B; j++) begin
         if ({beat_q, OFF_W'(j)} < drain_len) new_keep[j] = 1'b1;
         if ({beat_q, OFF_W'(j)} < size_q[drain_ptr_q]) new_data[8*j +: 8] = rd_word[8*j +: 8];
      end
      new_last = (beat_q == beats - 1'b1);
      // Reads are only issued while the skid is empty, so an issued word always has a home
      // even if tready is low this cycle.
      issue      = (state_q != IDLE) && (beat_q < beats) && !skid_vld_q;
      pop        = tvalid_q && tx_axis_tready_i;
      frame_done = pop && tlast_q;
   end

   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      committed_d = committed_q;
      fill_ptr_d  = fill_ptr_q;
      drain_ptr_d = drain_ptr_q;
      beat_d      = beat_q;
      count_d     = count_q;
      tdata_d     = tdata_q;
      tkeep_d     = tkeep_q;
      tlast_d     = tlast_q;
      tvalid_d    = tvalid_q;
      skid_data_d = skid_data_q;
      skid_keep_d = skid_keep_q;
      skid_last_d = skid_last_q;
      skid_vld_d  = skid_vld_q;

      // Host side: a size latched this cycle is what the commit sees.
      fill_size = size_q[fill_ptr_q];
      if (packet_wsize_valid_i && host_ok) begin
         fill_size          = clamp_size(packet_wsize_i);
         size_d[fill_ptr_q] = fill_size;
      end
      // A zero-length commit never leaves the fill slot, so the slot stays free.
      commit = packet_send_i && host_ok && (fill_size != '0);

      if (issue) beat_d = beat_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (committed_q[drain_ptr_q]) begin
               beat_d  = '0;
               state_d = FETCH;
            end
         end
         FETCH: state_d = STREAM;
         default: begin
            if (frame_done) begin
               committed_d[drain_ptr_q] = 1'b0;
               drain_ptr_d              = ~drain_ptr_q;
               count_d                  = sat_inc(count_q);
               if (committed_q[~drain_ptr_q]) begin
                  beat_d  = '0;
                  state_d = FETCH;
               end else begin
                  state_d = IDLE;
               end
            end
         end
      endcase

      // Applied after the drain update so a same-cycle free of the other slot is kept.
      if (commit) begin
         committed_d[fill_ptr_q] = 1'b1;
         fill_ptr_d              = ~fill_ptr_q;
      end

      // Output register refills from the skid first, then from the new read.
      if (!tvalid_q || tx_axis_tready_i) begin
         if (skid_vld_q) begin
            tdata_d    = skid_data_q;
            tkeep_d    = skid_keep_q;
            tlast_d    = skid_last_q;
            tvalid_d   = 1'b1;
            skid_vld_d = 1'b0;
         end else if (issue) begin
            tdata_d  = new_data;
            tkeep_d  = new_keep;
            tlast_d  = new_last;
            tvalid_d = 1'b1;
         end else begin
            tvalid_d = 1'b0;
         end
      end else if (issue) begin
         skid_data_d = new_data;
         skid_keep_d = new_keep;
         skid_last_d = new_last;
         skid_vld_d  = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         size_q[0]   <= '0;
         size_q[1]   <= '0;
         committed_q <= '0;
         fill_ptr_q  <= 1'b0;
         drain_ptr_q <= 1'b0;
         beat_q      <= '0;
         count_q     <= '0;
         tdata_q     <= '0;
         tkeep_q     <= '0;
         tlast_q     <= 1'b0;
         tvalid_q    <= 1'b0;
         skid_data_q <= '0;
         skid_keep_q <= '0;
         skid_last_q <= 1'b0;
         skid_vld_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         committed_q <= committed_d;
         fill_ptr_q  <= fill_ptr_d;
         drain_ptr_q <= drain_ptr_d;
         beat_q      <= beat_d;
         count_q     <= count_d;
         tdata_q     <= tdata_d;
         tkeep_q     <= tkeep_d;
         tlast_q     <= tlast_d;
         tvalid_q    <= tvalid_d;
         skid_data_q <= skid_data_d;
         skid_keep_q <= skid_keep_d;
         skid_last_q <= skid_last_d;
         skid_vld_q  <= skid_vld_d;
      end
   end

   assign packet_req_o     = host_ok;
   assign tx_axis_tdata_o  = tdata_q;
   assign tx_axis_tkeep_o  = tkeep_q;
   assign tx_axis_tlast_o  = tlast_q;
   assign tx_axis_tvalid_o = tvalid_q;
   assign tx_axis_tuser_o  = 1'b0;
   assign transmit_count_o = count_q;

   // Host must not touch the slots while none is free; sizes must fit a slot.
   assert property (@(posedge clk_i) disable iff (reset_i)
      !(!packet_req_o && (packet_wvalid_i || packet_wsize_valid_i || packet_send_i)));
   assert property (@(posedge clk_i) disable iff (reset_i)
      !(packet_wsize_valid_i && packet_wsize_i > SIZE_W'(eth_mtu_p)));

endmodule

// File: tb/tb_ethernet_transmitter.sv
module tb_ethernet_transmitter;
   localparam int DW  = 32;
   localparam int MTU = 2048;
   localparam int B   = DW / 8;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        packet_req_o;
   logic        packet_wvalid_i = 1'b0;
   logic [10:0] packet_waddr_i = '0;
   logic [31:0] packet_wdata_i = '0;
   logic [3:0]  packet_wmask_i = '0;
   logic        packet_wsize_valid_i = 1'b0;
   logic [11:0] packet_wsize_i = '0;
   logic        packet_send_i = 1'b0;
   logic [31:0] tx_axis_tdata_o;
   logic [3:0]  tx_axis_tkeep_o;
   logic        tx_axis_tvalid_o;
   logic        tx_axis_tready_i = 1'b1;
   logic        tx_axis_tlast_o;
   logic        tx_axis_tuser_o;
   logic [15:0] transmit_count_o;

   always #5 clk_i = ~clk_i;

   ethernet_transmitter #(.data_width_p(DW), .eth_mtu_p(MTU), .send_count_p(65535)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .packet_req_o(packet_req_o),
      .packet_wvalid_i(packet_wvalid_i), .packet_waddr_i(packet_waddr_i),
      .packet_wdata_i(packet_wdata_i), .packet_wmask_i(packet_wmask_i),
      .packet_wsize_valid_i(packet_wsize_valid_i), .packet_wsize_i(packet_wsize_i),
      .packet_send_i(packet_send_i), .tx_axis_tdata_o(tx_axis_tdata_o),
      .tx_axis_tkeep_o(tx_axis_tkeep_o), .tx_axis_tvalid_o(tx_axis_tvalid_o),
      .tx_axis_tready_i(tx_axis_tready_i), .tx_axis_tlast_o(tx_axis_tlast_o),
      .tx_axis_tuser_o(tx_axis_tuser_o), .transmit_count_o(transmit_count_o)
   );

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   beat_t       mon_e;
   logic [7:0]  fb [0:MTU-1];
   int          n_checks = 0;
   int          n_errors = 0;
   int          model_cnt = 0;
   int          sent_frames = 0;
   int          tready_mode = 0;
   bit          stall_q = 1'b0;
   bit          cnt_pend = 1'b0;
   logic [63:0] held = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      packet_wvalid_i      = 1'b0;
      packet_wmask_i       = '0;
      packet_wsize_valid_i = 1'b0;
      packet_send_i        = 1'b0;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!packet_req_o && n < 5000) begin
         tick();
         n++;
      end
      check_eq("req_wait", 64'(packet_req_o), 64'd1);
   endtask

   // Expected wire image of a frame, built from its byte contents.
   task automatic expect_frame(input int size);
      int    len;
      int    nb;
      beat_t e;
      if (size == 0) return;
      len = size;
`ifdef ETHERNET_TX_MIN_FRAME_PAD_EN
      if (len < 60) len = 60;
`endif
      nb = (len + B - 1) / B;
      for (int k = 0; k < nb; k++) begin
         e.data = '0;
         e.keep = '0;
         for (int j = 0; j < B; j++) begin
            if (k * B + j < len) e.keep[j] = 1'b1;
            if (k * B + j < size) e.data[8*j +: 8] = fb[k * B + j];
         end
         e.last = (k == nb - 1);
         exp_q.push_back(e);
      end
      sent_frames++;
   endtask

   // dbl: write each word twice, the second time with a random byte mask.
   task automatic send_frame(input int size, input bit dbl, input bit seq);
      int          words;
      logic [31:0] junk;
      logic [31:0] d;
      logic [3:0]  m;
      words = (size + B - 1) / B;
      for (int i = 0; i < words * B; i++) fb[i] = seq ? 8'(i) : 8'($urandom);
      wait_req();
      for (int w = 0; w < words; w++) begin
         m = 4'hF;
         if (dbl) begin
            junk = $urandom;
            packet_wvalid_i = 1'b1;
            packet_waddr_i  = 11'(w * B);
            packet_wdata_i  = junk;
            packet_wmask_i  = 4'hF;
            tick();
            idle_inputs();
            m = 4'($urandom);
            for (int j = 0; j < B; j++) if (!m[j]) fb[w * B + j] = junk[8*j +: 8];
         end
         for (int j = 0; j < B; j++) d[8*j +: 8] = m[j] ? fb[w * B + j] : 8'($urandom);
         packet_wvalid_i = 1'b1;
         packet_waddr_i  = 11'(w * B + int'($urandom_range(0, 3)));
         packet_wdata_i  = d;
         packet_wmask_i  = m;
         if (w == words - 1) begin
            packet_wsize_valid_i = 1'b1;
            packet_wsize_i       = 12'(size);
            packet_send_i        = 1'b1;
         end
         tick();
         idle_inputs();
      end
      if (words == 0) begin
         packet_wsize_valid_i = 1'b1;
         packet_wsize_i       = 12'(size);
         packet_send_i        = 1'b1;
         tick();
         idle_inputs();
      end
      expect_frame(size);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || tx_axis_tvalid_o) && n < 20000) begin
         tick();
         n++;
      end
      check_eq("drain_done", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      tick();
      tick();
   endtask

   // Sink ready pattern.
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         case (tready_mode)
            0:       tx_axis_tready_i = 1'b1;
            1:       tx_axis_tready_i = ~tx_axis_tready_i;
            default: tx_axis_tready_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Stream monitor, sampled on the falling edge.
   always @(negedge clk_i) begin
      if (reset_i) begin
         stall_q  = 1'b0;
         cnt_pend = 1'b0;
      end else begin
         if (cnt_pend) begin
            check_eq("count", 64'(transmit_count_o), 64'(model_cnt));
            cnt_pend = 1'b0;
         end
         if (stall_q) begin
            check_eq("hold_valid", 64'(tx_axis_tvalid_o), 64'd1);
            check_eq("hold_data", {27'd0, tx_axis_tlast_o, tx_axis_tkeep_o, tx_axis_tdata_o}, held);
         end
         if (tx_axis_tvalid_o && tx_axis_tready_i) begin
            check_eq("beat_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check_eq("beat", {27'd0, tx_axis_tlast_o, tx_axis_tkeep_o, tx_axis_tdata_o},
                        {27'd0, mon_e.last, mon_e.keep, mon_e.data});
               if (mon_e.last) begin
                  model_cnt++;
                  cnt_pend = 1'b1;
               end
            end
         end
         stall_q = tx_axis_tvalid_o && !tx_axis_tready_i;
         held    = {27'd0, tx_axis_tlast_o, tx_axis_tkeep_o, tx_axis_tdata_o};
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (3) tick();
      check_eq("rst_req", 64'(packet_req_o), 64'd1);
      check_eq("rst_tvalid", 64'(tx_axis_tvalid_o), 64'd0);
      check_eq("rst_tlast", 64'(tx_axis_tlast_o), 64'd0);
      check_eq("rst_tkeep", 64'(tx_axis_tkeep_o), 64'd0);
      check_eq("rst_tdata", 64'(tx_axis_tdata_o), 64'd0);
      check_eq("rst_count", 64'(transmit_count_o), 64'd0);
      check_eq("tuser", 64'(tx_axis_tuser_o), 64'd0);
      reset_i = 1'b0;
      tick();

      // 16 sequential bytes; first tvalid two cycles after the commit is seen
      send_frame(16, 1'b0, 1'b1);
      check_eq("lat_c0", 64'(tx_axis_tvalid_o), 64'd0);
      tick();
      check_eq("lat_c1", 64'(tx_axis_tvalid_o), 64'd0);
      tick();
      check_eq("lat_c2", 64'(tx_axis_tvalid_o), 64'd1);
      check_eq("first_word", 64'(tx_axis_tdata_o), 64'h03020100);
      wait_drain();
      check_eq("count_t1", 64'(transmit_count_o), 64'(sent_frames));

      // 13-byte frame: partial last beat
      send_frame(13, 1'b0, 1'b0);
      wait_drain();

      // Two 8-byte frames back to back
      send_frame(8, 1'b0, 1'b0);
      send_frame(8, 1'b0, 1'b0);
      check_eq("b2b_req0", 64'(packet_req_o), 64'd0);
      check_eq("b2b_v0", 64'(tx_axis_tvalid_o), 64'd1);
      tick();
      check_eq("b2b_req1", 64'(packet_req_o), 64'd0);
      check_eq("b2b_last1", 64'(tx_axis_tvalid_o && tx_axis_tlast_o), 64'd1);
      tick();
      check_eq("b2b_gap", 64'(tx_axis_tvalid_o), 64'd0);
      check_eq("b2b_req2", 64'(packet_req_o), 64'd1);
      tick();
      check_eq("b2b_v3", 64'(tx_axis_tvalid_o), 64'd1);
      wait_drain();
      check_eq("count_t3", 64'(transmit_count_o), 64'(sent_frames));

      // 64-byte frame with tready toggling every cycle
      tready_mode = 1;
      send_frame(64, 1'b1, 1'b0);
      wait_drain();
      tready_mode = 0;
      tick();

      // Zero-length frame is dropped, then a 4-byte frame
      send_frame(0, 1'b0, 1'b0);
      repeat (3) tick();
      check_eq("drop_tvalid", 64'(tx_axis_tvalid_o), 64'd0);
      check_eq("drop_req", 64'(packet_req_o), 64'd1);
      send_frame(4, 1'b0, 1'b0);
      wait_drain();
      check_eq("count_t5", 64'(transmit_count_o), 64'(sent_frames));

      // Reset in the middle of a 64-byte frame
      send_frame(64, 1'b0, 1'b0);
      repeat (6) tick();
      check_eq("mid_tvalid", 64'(tx_axis_tvalid_o), 64'd1);
      reset_i = 1'b1;
      tick();
      check_eq("rst_mid_tvalid", 64'(tx_axis_tvalid_o), 64'd0);
      check_eq("rst_mid_count", 64'(transmit_count_o), 64'd0);
      check_eq("rst_mid_req", 64'(packet_req_o), 64'd1);
      exp_q.delete();
      model_cnt   = 0;
      sent_frames = 0;
      reset_i = 1'b0;
      tick();

      // Short frame (padding depends on build)
      send_frame(20, 1'b0, 1'b0);
      wait_drain();
      check_eq("count_t6", 64'(transmit_count_o), 64'(sent_frames));

      // Random frames, random masks, random backpressure
      tready_mode = 2;
      for (int f = 0; f < 30; f++) begin
         send_frame(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 130)), 1'b1, 1'b0);
         repeat ($urandom_range(0, 4)) tick();
      end
      wait_drain();
      check_eq("count_rand", 64'(transmit_count_o), 64'(sent_frames));
      check_eq("end_req", 64'(packet_req_o), 64'd1);
      check_eq("end_tvalid", 64'(tx_axis_tvalid_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
